// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial transmit path.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: tick_o marks the last clock of each CLKS_PER_BIT period.
// Count holds at zero whenever run_i is low, so every frame starts on a clean period.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tick_o
);

  localparam int CW = clog2_min1(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial framer: start bit, DATA_W bits LSB first, stop bit, each CLKS_PER_BIT clocks.
// Start bit appears one cycle after accept; ready_o only in IDLE, words offered while busy are dropped.
module serial_tx_framer
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              o
);

  localparam int BW = clog2_min1(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic              o_q, o_d;
  logic              busy_q, busy_d;
  logic              tick;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .run_i (state_q != IDLE),
    .tick_o(tick)
  );

  assign ready_o = (state_q == IDLE) && !rst;
  assign busy_o  = busy_q;
  assign o       = o_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          state_d   = START;
          shift_d   = data_i;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value is decoded from the next state so o is a clean flop output.
    o_d = LINE_IDLE;
    case (state_d)
      START:   o_d = START_BIT;
      DATA:    o_d = shift_d[0];
      STOP:    o_d = STOP_BIT;
      default: o_d = LINE_IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      o_q       <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      o_q       <= o_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: a 4-clock-per-bit and a 1-clock-per-bit instance driven in parallel.
module tb_serial_tx_framer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          rdy4, busy4, o4;
  logic          rdy1, busy1, o1;

  serial_tx_framer #(.DATA_W(DW), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid),
    .ready_o(rdy4), .busy_o(busy4), .o(o4)
  );

  serial_tx_framer #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid),
    .ready_o(rdy1), .busy_o(busy1), .o(o1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected line values, one entry per clock, for each instance.
  bit q4[$];
  bit q1[$];

  logic s_o4, s_r4, s_b4, s_o1, s_r1, s_b1;

  typedef struct {
    logic [DW-1:0] d;
    logic [DW+1:0] bits;
  } vec_t;
  vec_t tbl[5];

  function automatic bit frame_bit(input logic [DW-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic v, input logic [DW-1:0] d);
    bit acc;
    rst   = r;
    valid = v;
    data  = d;
    @(negedge clk);
    s_o4 = o4; s_r4 = rdy4; s_b4 = busy4;
    s_o1 = o1; s_r1 = rdy1; s_b1 = busy1;
    chk("model o cpb4",     o4,    (q4.size() > 0) ? q4[0] : 1'b1);
    chk("model ready cpb4", rdy4,  (q4.size() == 0) && !r);
    chk("model busy cpb4",  busy4, q4.size() > 0);
    chk("model o cpb1",     o1,    (q1.size() > 0) ? q1[0] : 1'b1);
    chk("model ready cpb1", rdy1,  (q1.size() == 0) && !r);
    chk("model busy cpb1",  busy1, q1.size() > 0);
    @(posedge clk);
    if (r) begin
      q4.delete();
      q1.delete();
    end else begin
      acc = v && (q4.size() == 0);
      if (q4.size() > 0) void'(q4.pop_front());
      if (acc) for (int k = 0; k < DW + 2; k++) repeat (4) q4.push_back(frame_bit(d, k));
      acc = v && (q1.size() == 0);
      if (q1.size() > 0) void'(q1.pop_front());
      if (acc) for (int k = 0; k < DW + 2; k++) q1.push_back(frame_bit(d, k));
    end
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick(1'b0, 1'b0, '0);
  endtask

  initial begin
    // bits[i] is the i-th value seen on the line: start, d[0..7], stop.
    tbl[0] = '{d: 8'hA5, bits: 10'b11_0100_1010};
    tbl[1] = '{d: 8'h81, bits: 10'b11_0000_0010};
    tbl[2] = '{d: 8'h00, bits: 10'b10_0000_0000};
    tbl[3] = '{d: 8'hFF, bits: 10'b11_1111_1110};
    tbl[4] = '{d: 8'h3C, bits: 10'b10_0111_1000};

    rst = 1'b1; valid = 1'b0; data = '0;
    @(posedge clk);
    #1;

    tick(1'b1, 1'b0, '0);
    chk("reset o", s_o4, 1'b1);
    chk("reset busy", s_b4, 1'b0);
    chk("reset ready", s_r4, 1'b0);

    for (int i = 0; i < 5; i++) begin
      drain(3);
      tick(1'b0, 1'b1, tbl[i].d);
      for (int t = 0; t < 40; t++) begin
        tick(1'b0, 1'b0, '0);
        chk($sformatf("vec%0d o4 t%0d", i, t), s_o4, tbl[i].bits[t/4]);
        chk($sformatf("vec%0d ready4 t%0d", i, t), s_r4, 1'b0);
        if (t < 10) chk($sformatf("vec%0d o1 t%0d", i, t), s_o1, tbl[i].bits[t]);
      end
      tick(1'b0, 1'b0, '0);
      chk($sformatf("vec%0d ready4 after", i), s_r4, 1'b1);
      chk($sformatf("vec%0d o4 after", i), s_o4, 1'b1);
    end

    // Back-to-back with valid held high.
    drain(3);
    tick(1'b0, 1'b1, 8'h00);
    repeat (40) tick(1'b0, 1'b1, 8'hFF);
    chk("b2b gap o4", s_o4, 1'b1);
    tick(1'b0, 1'b1, 8'hFF);
    chk("b2b gap ready4", s_r4, 1'b1);
    chk("b2b gap line", s_o4, 1'b1);
    for (int t = 0; t < 40; t++) begin
      tick(1'b0, 1'b0, '0);
      chk($sformatf("b2b o4 t%0d", t), s_o4, (t >= 4));
    end

    // Word offered mid-frame must be dropped.
    drain(45);
    tick(1'b0, 1'b1, 8'h81);
    for (int t = 0; t < 40; t++) begin
      if (t == 6) tick(1'b0, 1'b1, 8'h3C);
      else        tick(1'b0, 1'b0, '0);
      chk($sformatf("mid o4 t%0d", t), s_o4, tbl[1].bits[t/4]);
      if (t == 6) chk("mid busy4", s_b4, 1'b1);
    end
    repeat (10) begin
      tick(1'b0, 1'b0, '0);
      chk("mid no extra o4", s_o4, 1'b1);
      chk("mid no extra busy4", s_b4, 1'b0);
    end

    // One-cycle reset at cycle 10 of a frame.
    drain(3);
    tick(1'b0, 1'b1, 8'hA5);
    repeat (10) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    chk("rst ready4 during", s_r4, 1'b0);
    tick(1'b0, 1'b1, 8'h81);
    chk("rst o4 after", s_o4, 1'b1);
    chk("rst busy4 after", s_b4, 1'b0);
    chk("rst ready4 after", s_r4, 1'b1);
    for (int t = 0; t < 40; t++) begin
      tick(1'b0, 1'b0, '0);
      chk($sformatf("post-rst o4 t%0d", t), s_o4, tbl[1].bits[t/4]);
    end

    // Reset held with valid high.
    drain(3);
    repeat (3) begin
      tick(1'b1, 1'b1, 8'hA5);
      chk("rst-held o4", s_o4, 1'b1);
      chk("rst-held ready4", s_r4, 1'b0);
      chk("rst-held busy4", s_b4, 1'b0);
    end
    tick(1'b0, 1'b1, 8'hA5);
    chk("rst-release ready4", s_r4, 1'b1);
    chk("rst-release o4", s_o4, 1'b1);
    tick(1'b0, 1'b0, '0);
    chk("rst-release start o4", s_o4, 1'b0);
    chk("rst-release busy4", s_b4, 1'b1);

    // Random traffic against the frame model.
    drain(45);
    repeat (600) begin
      tick($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
    end
    drain(45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
